// File: rtl/exc_seq.sv
// Exception/interrupt sequencer: flushes for a drain window, then redirects the PC to the handler or to EPC on ERET.
// Optional taken-interrupt counter enabled by defining EXC_SEQ_CNT_EN.
module exc_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        eret_m,
  input  logic        m_valid,
  input  logic        stall,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [31:0] epc,
  output logic [31:0] cp0_pca4,
  output logic        cp0_bd,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        exl_clr,
  output logic        busy,
  output logic [15:0] int_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_REDIR,
    S_ERET
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             eret_go;

  always_comb begin
    take    = int_req & m_valid & ~stall;
    eret_go = eret_m & m_valid & ~stall & ~int_req;
  end

  assign cp0_pca4 = pc_m + 32'd4;
  assign cp0_bd   = bd_m;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      flush       <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      exl_clr     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            state <= S_DRAIN;
            cnt   <= CNT_W'(DRAIN_CYCLES - 1);
            flush <= 1'b1;
          end else if (eret_go) begin
            state       <= S_ERET;
            flush       <= 1'b1;
            pc_redirect <= 1'b1;
            redirect_pc <= epc;
            exl_clr     <= 1'b1;
          end else begin
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            exl_clr     <= 1'b0;
          end
        end
        // Drain counts down unconditionally; stall only gates entry.
        S_DRAIN: begin
          flush <= 1'b1;
          if (cnt == '0) begin
            state       <= S_REDIR;
            pc_redirect <= 1'b1;
            redirect_pc <= HANDLER_ADDR;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_REDIR, S_ERET: begin
          state       <= S_IDLE;
          flush       <= 1'b0;
          pc_redirect <= 1'b0;
          exl_clr     <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          flush       <= 1'b0;
          pc_redirect <= 1'b0;
          exl_clr     <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_SEQ_CNT_EN
  logic [15:0] int_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_cnt_q <= '0;
    end else if (state == S_IDLE && take && int_cnt_q != 16'hFFFF) begin
      int_cnt_q <= int_cnt_q + 16'd1;
    end
  end

  assign int_count = int_cnt_q;
`else
  assign int_count = '0;
`endif

endmodule
